// File: rtl/aes_128_ctrl_if.sv
// aes_128_ctrl_if: plaintext in / ciphertext out valid-ready handshake bundle
interface aes_128_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_128_ctrl.sv
// aes_128_ctrl: AES-128 round sequencer with round-key file, timeout abort and valid/ready front end
module aes_128_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          kill,
    aes_128_ctrl_if.slave bus,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [127:0]  cfg_data,
    output logic          cfg_err,
    output logic          busy,
    output logic          err,
    output logic [127:0]  core_in_data,
    output logic          core_in_en,
    output logic [127:0]  core_key,
    output logic          core_last,
    input  logic [127:0]  core_out_data,
    input  logic          core_out_en
);
    localparam int CW = $clog2(TIMEOUT + ROUND_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0] key_q [NR+1];
    logic [127:0] key_d [NR+1];
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic err_q, err_d, cfg_err_q, cfg_err_d, core_in_en_q, core_in_en_d, core_last_q, core_last_d;
    logic [127:0] out_data_q, out_data_d, core_in_data_q, core_in_data_d, core_key_q, core_key_d;
    logic cfg_ok, issue;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign cfg_err       = cfg_err_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign core_in_data  = core_in_data_q;
    assign core_in_en    = core_in_en_q;
    assign core_key      = core_key_q;
    assign core_last     = core_last_q;
    // next-state, key file writes and registered-output values
    always_comb begin
        cfg_ok = cfg_we && state_q == IDLE && cfg_addr <= 4'(NR);
        key_d = key_q;
        if (cfg_ok) key_d[cfg_addr] = cfg_data;
        state_d = state_q;
        round_d = round_q;
        blk_d = blk_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid && in_ready_q) begin
                blk_d = bus.in_data ^ key_q[0];
                round_d = 4'd1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d = '0;
                state_d = WAIT;
            end
            WAIT: if (core_out_en) begin
                blk_d = core_out_data;
                state_d = round_q == 4'(NR) ? DONE : ISSUE;
                round_d = round_q == 4'(NR) ? round_q : round_q + 4'd1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                err_d = 1'b1;
                blk_d = '0;
                round_d = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = bus.out_ready ? IDLE : DONE;
        endcase
        issue = state_d == ISSUE;
        in_ready_d = state_d == IDLE;
        busy_d = state_d != IDLE;
        out_valid_d = state_d == DONE;
        out_data_d = (state_q == WAIT && state_d == DONE) ? blk_d : out_data_q;
        core_in_en_d = issue;
        core_last_d = issue && round_d == 4'(NR);
        core_in_data_d = issue ? blk_d : core_in_data_q;
        core_key_d = issue ? key_d[round_d] : core_key_q;
        cfg_err_d = cfg_we && !cfg_ok;
    end
    // state and output registers; kill clears everything including the key file
    always_ff @(posedge clk) begin
        if (!kill) begin
            state_q        <= IDLE;
            round_q        <= '0;
            blk_q          <= '0;
            cnt_q          <= '0;
            key_q          <= '{default: '0};
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            cfg_err_q      <= 1'b0;
            core_in_en_q   <= 1'b0;
            core_last_q    <= 1'b0;
            out_data_q     <= '0;
            core_in_data_q <= '0;
            core_key_q     <= '0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            blk_q          <= blk_d;
            cnt_q          <= cnt_d;
            key_q          <= key_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            cfg_err_q      <= cfg_err_d;
            core_in_en_q   <= core_in_en_d;
            core_last_q    <= core_last_d;
            out_data_q     <= out_data_d;
            core_in_data_q <= core_in_data_d;
            core_key_q     <= core_key_d;
        end
    end
endmodule

// File: doc/aes_128_ctrl.md
# aes_128_ctrl

Round sequencer for the iterative AES-128 round core (S-box in 4 BRAM, 3-cycle round). The block holds the 11 round keys in a configurable key register file, accepts one plaintext block over a valid/ready handshake, and performs the initial AddRoundKey itself. It then drives the round core once per round, feeding each result back, and sets the last-round flag on the final pass. The ciphertext is returned over a valid/ready handshake. The block sits between the system-side requester and the round core, and owns all round counting and key selection.

## Interface
- NR, 10, number of cipher rounds; key file depth is NR+1
- ROUND_LAT, 3, core latency: cycles from core_in_en to core_out_en
- TIMEOUT, 15, maximum cycles spent in WAIT before abort
- clk  in  1  single clock, all logic on rising edge
- kill  in  1  reset, synchronous, active-low
- cfg_we  in  1  round-key write strobe
- cfg_addr  in  4  round-key index 0..NR
- cfg_data  in  128  round-key value
- cfg_err  out  1  one-cycle pulse: write rejected
- in_valid  in  1  plaintext offered
- in_ready  out  1  block can accept plaintext
- in_data  in  128  plaintext
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext
- busy  out  1  encryption in progress
- err  out  1  one-cycle pulse: core timeout abort
- core_in_data  out  128  state to round core
- core_in_en  out  1  one-cycle round start
- core_key  out  128  round key for this round
- core_last  out  1  final round (no MixColumns)
- core_out_data  in  128  round result
- core_out_en  in  1  round result valid (one cycle)

## Operation
- The key file holds NR+1 x 128-bit registers. A write occurs when cfg_we=1 and the block is in IDLE with addr <= NR.
- A cfg_we with addr > NR, or any cfg_we outside IDLE, leaves the key file unchanged and pulses cfg_err on the next cycle.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture state = in_data ^ key[0], set round=1, go to ISSUE.
  - ISSUE: one cycle. Drive core_in_en=1, core_in_data=state, core_key=key[round], core_last=(round==NR). Clear the wait counter. Go to WAIT.
  - WAIT: the wait counter increments each cycle.
    - On core_out_en: state <= core_out_data. If round==NR, go to DONE; otherwise round+1 and go to ISSUE.
    - If the counter reaches TIMEOUT without core_out_en: pulse err, go to IDLE, discard the block.
  - DONE: out_valid=1 and out_data=state. Both are held stable until out_ready=1, then go to IDLE.
- busy=1 in ISSUE, WAIT and DONE.
- core_out_en outside WAIT is ignored.
- out_data keeps its last value after the handshake completes.
- in_valid outside IDLE is ignored; in_ready=0 there.
- The round counter is 4 bits, saturates at NR, and never wraps.

## Timing
- Reset (kill=0 at an edge) forces IDLE, round=0, state=0 and the following output values:
  - out_valid=0, out_data=0, core_in_en=0, core_last=0, core_in_data=0, core_key=0, err=0, cfg_err=0, busy=0.
  - in_ready=0 while kill=0, and 1 from the first cycle after release.
  - The key file is cleared to 0.
- Reset mid-operation aborts immediately: no out_valid and no err.
- With the accept edge at T:
  - Round r issues at T+1+(r-1)(ROUND_LAT+1).
  - out_valid first asserts at T + NR*(ROUND_LAT+1) + 1, which is T+41 for the defaults.
- Back-to-back blocks: in_ready returns the cycle after the out handshake. The next accept therefore comes at least 1 cycle after the out_ready edge.
- cfg_we and in_valid in the same IDLE cycle: the write completes, and the capture uses the old key[0] value.

## Test plan
- FIPS-197 vector, default parameters:
  - Load keys 0..10 expanded from key 000102030405060708090a0b0c0d0e0f. Send 00112233445566778899aabbccddeeff with out_ready=1.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T+41.
  - Required: exactly 10 core_in_en pulses, with core_last=1 only on the 10th.
- Output backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_valid and out_data stable, in_ready=0. Release -> IDLE next cycle, and a second block is accepted and completes correctly.
- Config protection:
  - cfg_we to addr 5 during WAIT -> cfg_err pulse, key[5] unchanged.
  - cfg_we to addr 12 in IDLE -> cfg_err pulse.
  - cfg_we to addr 10 in IDLE -> key[10] updated, no cfg_err.
- Timeout:
  - Core model drops core_out_en for round 4.
  - Required: err pulses after exactly TIMEOUT cycles in WAIT, FSM returns to IDLE, and out_valid never asserts.
- Reset mid-run: kill=0 during round 6.
  - Required: all outputs at reset values the next cycle, and the key file cleared.
  - After reloading keys, the FIPS vector passes.
- Stray core_out_en in IDLE and in_valid during busy are both ignored, with no state change.
